// File: rtl/demux_1to2.sv
// demux_1to2: routes one valid/ready input stream into two independent
// 2-entry FIFO channels chosen by select_i. Each channel presents its head
// word with a valid/ready handshake. Reset (rst_i) is synchronous and
// active-low; while it is low every output reads as zero.
// Optional feature: define DEMUX_1TO2_CNT_EN to enable the 16-bit per-channel
// accepted-word counters on cnt0_o/cnt1_o. Without it those outputs are
// constant zero and no counter registers exist.
module demux_1to2 #(
  parameter int size = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic            select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic            valid0_o,
  output logic            valid1_o,
  input  logic            ready0_i,
  input  logic            ready1_i,
  output logic [15:0]     cnt0_o,
  output logic [15:0]     cnt1_o
);

  logic [1:0]            rdy_in;
  logic [1:0]            full;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            chan_valid;
  logic [1:0][size-1:0]  head;
  logic [1:0][15:0]      cnt;

  assign rdy_in = {ready1_i, ready0_i};

  // Acceptance depends only on registered fullness of the addressed channel,
  // so downstream ready never reaches ready_o combinationally.
  assign ready_o = rst_i && (select_i ? !full[1] : !full[0]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [size-1:0] mem_reg [2];
      logic            wr_ptr_reg;
      logic            rd_ptr_reg;
      logic [1:0]      occ_reg;
      logic [1:0]      occ_next;
      logic            sel_match;

      assign sel_match      = (gi == 1) ? select_i : ~select_i;
      assign full[gi]       = (occ_reg == 2'd2);
      assign chan_valid[gi] = rst_i && (occ_reg != 2'd0);
      assign push[gi]       = valid_i && rst_i && sel_match && !full[gi];
      assign pop[gi]        = chan_valid[gi] && rdy_in[gi];
      // Storage is cleared on reset, so the head reads zero until a push.
      assign head[gi]       = rst_i ? mem_reg[rd_ptr_reg] : '0;

      // Occupancy: a push and a pop in the same cycle cancel out.
      always_comb begin
        occ_next = occ_reg;
        case ({push[gi], pop[gi]})
          2'b10:   occ_next = occ_reg + 2'd1;
          2'b01:   occ_next = occ_reg - 2'd1;
          default: occ_next = occ_reg;
        endcase
      end

      // Ring of two words addressed by one-bit write/read pointers.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          mem_reg[0] <= '0;
          mem_reg[1] <= '0;
          wr_ptr_reg <= 1'b0;
          rd_ptr_reg <= 1'b0;
          occ_reg    <= 2'd0;
        end else begin
          if (push[gi]) begin
            mem_reg[wr_ptr_reg] <= data_i;
            wr_ptr_reg          <= ~wr_ptr_reg;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= ~rd_ptr_reg;
          end
          occ_reg <= occ_next;
        end
      end

`ifdef DEMUX_1TO2_CNT_EN
      logic [15:0] cnt_reg;

      // Free-running count of accepted words, wrapping at 16 bits.
      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          cnt_reg <= 16'd0;
        end else if (push[gi]) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end

      assign cnt[gi] = rst_i ? cnt_reg : 16'd0;
`else
      assign cnt[gi] = 16'd0;
`endif
    end
  endgenerate

  assign data0_o  = head[0];
  assign data1_o  = head[1];
  assign valid0_o = chan_valid[0];
  assign valid1_o = chan_valid[1];
  assign cnt0_o   = cnt[0];
  assign cnt1_o   = cnt[1];

endmodule

// File: tb/tb_demux_1to2.sv
// Testbench for demux_1to2: queue-based reference model updated on every
// rising edge, a per-cycle compare process on the falling edge, and directed
// scenarios with literal expectations plus a randomized ordering phase.
module tb_demux_1to2;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        sel;
  logic        vin;
  logic        rdy;
  logic [31:0] d0, d1;
  logic        v0, v1;
  logic        r0, r1;
  logic [15:0] c0, c1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 0;

  // Reference model state
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] ec0, ec1;
  bit          m_push0, m_push1, m_pop0, m_pop1;

  // Observed pops and the words offered during the random phase
  logic [31:0] obs0[$];
  logic [31:0] obs1[$];
  logic [31:0] in0[$];
  logic [31:0] in1[$];

  demux_1to2 #(.size(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .data_i   (data_in),
    .select_i (sel),
    .valid_i  (vin),
    .ready_o  (rdy),
    .data0_o  (d0),
    .data1_o  (d1),
    .valid0_o (v0),
    .valid1_o (v1),
    .ready0_i (r0),
    .ready1_i (r1),
    .cnt0_o   (c0),
    .cnt1_o   (c1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: two bounded queues, decisions taken on pre-edge state.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      ec0 = 16'd0;
      ec1 = 16'd0;
    end else begin
      m_push0 = vin && !sel && (q0.size() < 2);
      m_push1 = vin &&  sel && (q1.size() < 2);
      m_pop0  = r0 && (q0.size() > 0);
      m_pop1  = r1 && (q1.size() > 0);
      if (m_pop0) void'(q0.pop_front());
      if (m_pop1) void'(q1.pop_front());
      if (m_push0) begin q0.push_back(data_in); ec0 = ec0 + 16'd1; end
      if (m_push1) begin q1.push_back(data_in); ec1 = ec1 + 16'd1; end
    end
  end

  // Record words actually handed downstream by the DUT.
  always @(posedge clk) begin
    if (rst_n) begin
      if (v0 && r0) obs0.push_back(d0);
      if (v1 && r1) obs1.push_back(d1);
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_valid0", {63'd0, v0}, {63'd0, rst_n && (q0.size() > 0)});
      check("cyc_valid1", {63'd0, v1}, {63'd0, rst_n && (q1.size() > 0)});
      check("cyc_ready", {63'd0, rdy},
            {63'd0, rst_n && (sel ? (q1.size() < 2) : (q0.size() < 2))});
      if (rst_n && q0.size() > 0) check("cyc_data0", {32'd0, d0}, {32'd0, q0[0]});
      if (rst_n && q1.size() > 0) check("cyc_data1", {32'd0, d1}, {32'd0, q1[0]});
      if (!rst_n) begin
        check("cyc_rst_data0", {32'd0, d0}, 64'd0);
        check("cyc_rst_data1", {32'd0, d1}, 64'd0);
      end
`ifdef DEMUX_1TO2_CNT_EN
      check("cyc_cnt0", {48'd0, c0}, {48'd0, rst_n ? ec0 : 16'd0});
      check("cyc_cnt1", {48'd0, c1}, {48'd0, rst_n ? ec1 : 16'd0});
`else
      check("cyc_cnt0", {48'd0, c0}, 64'd0);
      check("cyc_cnt1", {48'd0, c1}, 64'd0);
`endif
    end
  end

  initial begin
    int pushes;
    int cycles;
    rst_n   = 1'b0;
    data_in = 32'd0;
    sel     = 1'b0;
    vin     = 1'b0;
    r0      = 1'b0;
    r1      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    #1;
    check("rst_valid0", {63'd0, v0}, 64'd0);
    check("rst_valid1", {63'd0, v1}, 64'd0);
    check("rst_ready", {63'd0, rdy}, 64'd0);
    check("rst_cnt0", {48'd0, c0}, 64'd0);
    check("rst_data0", {32'd0, d0}, 64'd0);

    // First transfer with one-cycle latency
    tick();
    rst_n = 1'b1; vin = 1'b1; sel = 1'b0; data_in = 32'hA5A5_0001; r0 = 1'b1;
    #1;
    check("first_ready", {63'd0, rdy}, 64'd1);
    check("first_valid0_pre", {63'd0, v0}, 64'd0);
    tick();
    vin = 1'b0;
    #1;
    check("first_valid0", {63'd0, v0}, 64'd1);
    check("first_data0", {32'd0, d0}, 64'hA5A5_0001);
    check("first_valid1", {63'd0, v1}, 64'd0);
    tick();
    r0 = 1'b0;

    // Fill channel 1 while channel 0 stays open
    r1 = 1'b0; vin = 1'b1; sel = 1'b1; data_in = 32'h11;
    tick();
    data_in = 32'h22;
    tick();
    vin = 1'b0;
    #1;
    check("full1_ready_sel1", {63'd0, rdy}, 64'd0);
    sel = 1'b0;
    #1;
    check("full1_ready_sel0", {63'd0, rdy}, 64'd1);
    check("full1_head", {32'd0, d1}, 64'h11);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;
    #1;
    check("pop1_head", {32'd0, d1}, 64'h22);
    check("pop1_valid", {63'd0, v1}, 64'd1);
    r1 = 1'b1;
    tick();
    r1 = 1'b0;

    // Simultaneous push and pop at occupancy 1
    vin = 1'b1; sel = 1'b0; data_in = 32'h7;
    tick();
    data_in = 32'h3; r0 = 1'b1;
    tick();
    vin = 1'b0; r0 = 1'b0;
    #1;
    check("pp_valid0", {63'd0, v0}, 64'd1);
    check("pp_data0", {32'd0, d0}, 64'h3);
    vin = 1'b1; data_in = 32'h4;
    tick();
    vin = 1'b0;
    #1;
    check("pp_occ_was_1", {63'd0, rdy}, 64'd0);
    r0 = 1'b1;
    tick();
    tick();
    r0 = 1'b0;
    #1;
    check("pp_drained", {63'd0, v0}, 64'd0);

    // Random-ready alternating pushes: per-channel order must be preserved
    obs0.delete(); obs1.delete(); in0.delete(); in1.delete();
    pushes = 0;
    cycles = 0;
    while (pushes < 10 && cycles < 300) begin
      sel     = pushes[0];
      vin     = 1'b1;
      data_in = $urandom;
      r0      = 1'($urandom_range(0, 1));
      r1      = 1'($urandom_range(0, 1));
      #1;
      if (rdy) begin
        if (sel) in1.push_back(data_in);
        else     in0.push_back(data_in);
        pushes++;
      end
      tick();
      cycles++;
    end
    check("rand_pushes_done", 64'(pushes), 64'd10);
    vin = 1'b0; r0 = 1'b1; r1 = 1'b1;
    repeat (6) tick();
    r0 = 1'b0; r1 = 1'b0;
    check("rand_n0", 64'(obs0.size()), 64'(in0.size()));
    check("rand_n1", 64'(obs1.size()), 64'(in1.size()));
    for (int i = 0; i < in0.size() && i < obs0.size(); i++)
      check($sformatf("rand_ch0_w%0d", i), {32'd0, obs0[i]}, {32'd0, in0[i]});
    for (int i = 0; i < in1.size() && i < obs1.size(); i++)
      check($sformatf("rand_ch1_w%0d", i), {32'd0, obs1[i]}, {32'd0, in1[i]});

    // Reset with both channels full
    vin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel     = k[0];
      data_in = 32'h100 + 32'(k);
      tick();
    end
    vin = 1'b0;
    #1;
    check("both_full_v0", {63'd0, v0}, 64'd1);
    check("both_full_ready", {63'd0, rdy}, 64'd0);
    rst_n = 1'b0; vin = 1'b1; r0 = 1'b1; r1 = 1'b1;
    #1;
    check("inrst_ready", {63'd0, rdy}, 64'd0);
    tick();
    rst_n = 1'b1; vin = 1'b0; r0 = 1'b0; r1 = 1'b0;
    #1;
    check("postrst_v0", {63'd0, v0}, 64'd0);
    check("postrst_v1", {63'd0, v1}, 64'd0);
    check("postrst_c0", {48'd0, c0}, 64'd0);
    check("postrst_c1", {48'd0, c1}, 64'd0);
    check("postrst_d0", {32'd0, d0}, 64'd0);
    check("postrst_d1", {32'd0, d1}, 64'd0);

    // Counter wrap (or constant zero without the counters)
    vin = 1'b1; sel = 1'b0; r0 = 1'b1;
`ifdef DEMUX_1TO2_CNT_EN
    for (int n = 0; n < 65535; n++) begin
      data_in = 32'(n);
      tick();
    end
    check("cnt0_ffff", {48'd0, c0}, 64'hFFFF);
    tick();
    check("cnt0_wrap", {48'd0, c0}, 64'd0);
`else
    repeat (20) tick();
    check("cnt0_absent", {48'd0, c0}, 64'd0);
`endif
    vin = 1'b0;
    repeat (3) tick();
    r0 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/demux_1to2.md
DEMUX_1TO2 -- requirements
Module: demux_1to2

Interface
REQ-001 The module SHALL have parameter: size, 32, width in bits of the data word.
REQ-002 The module SHALL have port: clk_i  input  1  system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port: rst_i  input  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
REQ-004 The module SHALL have port: data_i  input  size  input word.
REQ-005 The module SHALL have port: select_i  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
REQ-006 The module SHALL have port: valid_i  input  1  data_i/select_i hold a word offered for transfer.
REQ-007 The module SHALL have port: ready_o  output  1  the offered word is accepted this cycle.
REQ-008 The module SHALL have port: data0_o, data1_o  output  size  head word of channel 0 / channel 1.
REQ-009 The module SHALL have port: valid0_o, valid1_o  output  1  channel holds at least one word.
REQ-010 The module SHALL have port: ready0_i, ready1_i  input  1  downstream consumes the head word of the channel.
REQ-011 The module SHALL have port: cnt0_o, cnt1_o  output  16  accepted-word counters per channel.

Function
REQ-012 Each channel SHALL contain an independent 2-entry FIFO holding size-bit words, in order.
REQ-013 An input transfer (push) SHALL occur on a clock edge where valid_i=1 and ready_o=1; the word is written to the FIFO selected by select_i.
REQ-014 ready_o SHALL be 1 when the FIFO selected by select_i holds fewer than 2 words, and 0 otherwise.
REQ-015 ready_o SHALL be derived only from registered occupancy and select_i, with no combinational path from ready0_i/ready1_i.
REQ-016 validN_o SHALL equal 1 when channel N occupancy > 0; dataN_o SHALL present the oldest word of channel N, and is don't-care when validN_o=0.
REQ-017 A pop of channel N SHALL occur on a clock edge where validN_o=1 and readyN_i=1.
REQ-018 On a simultaneous push and pop of the same channel, occupancy SHALL be unchanged and order preserved, including at occupancy 1; a push to a full channel cannot coincide with it, per REQ-014.
REQ-019 Push latency SHALL be one cycle: a word accepted at edge k SHALL appear on validN_o/dataN_o after edge k when the FIFO was empty.
REQ-020 Pushes to one channel and pops from the other SHALL proceed in the same cycle independently.
REQ-021 A full or stalled channel SHALL NOT block pushes to the other channel.
REQ-022 Sources SHALL hold data_i and select_i stable while valid_i=1 and ready_o=0; if select_i changes anyway, ready_o SHALL track the new select_i, and no word is duplicated or lost.
REQ-023 readyN_i asserted while validN_o=0 SHALL have no effect.
REQ-024 The words of a channel SHALL never be reordered, duplicated or dropped.

Reset
REQ-025 When rst_i=0 at a clock edge, both FIFOs SHALL be emptied and both counters cleared, regardless of pushes or pops in that cycle.
REQ-026 During and after reset: valid0_o=0, valid1_o=0, cnt0_o=0, cnt1_o=0, data0_o=0, data1_o=0.
REQ-027 During reset, ready_o SHALL be 0.
REQ-028 Words in flight when reset is asserted mid-operation SHALL be discarded.

Configuration
REQ-029 With macro DEMUX_1TO2_CNT_EN defined, cntN_o SHALL increment by 1 on every push to channel N, wrapping from 16'hFFFF to 0.
REQ-030 Without DEMUX_1TO2_CNT_EN, the counter registers SHALL be absent and cnt0_o/cnt1_o SHALL be constant 0.
REQ-031 All other behaviour SHALL be identical with and without DEMUX_1TO2_CNT_EN.

Verification
REQ-032 The bench SHALL cover: reset, then valid_i=1, select_i=0, data_i=32'hA5A5_0001, ready0_i=1 -> ready_o=1, next cycle valid0_o=1, data0_o=32'hA5A5_0001, valid1_o=0.
REQ-033 The bench SHALL cover: ready1_i=0, push 32'h11 then 32'h22 to channel 1 -> after the second push ready_o=0 with select_i=1 and ready_o=1 with select_i=0; data1_o=32'h11, then 32'h22 after one pop.
REQ-034 The bench SHALL cover: channel 0 at occupancy 1, simultaneous push 32'h3 and pop -> occupancy stays 1, data0_o changes to 32'h3, no loss.
REQ-035 The bench SHALL cover: 10 alternating-select pushes with random readyN_i -> each channel output sequence equals its input subsequence in order.
REQ-036 The bench SHALL cover: both channels full, rst_i=0 for one edge -> valid0_o=valid1_o=0 and cnt0_o=cnt1_o=0 after the edge.
REQ-037 The bench SHALL cover: with DEMUX_1TO2_CNT_EN, cnt0_o preloaded to 16'hFFFF by 65535 pushes, one more push -> cnt0_o=0; without the macro -> cnt0_o stays 0 throughout.
